// File: rtl/safe_cpu_reg_responder.sv
// OBI responder for the safe-CPU register window: redundancy mode, core enables,
// boot address, interrupt pend/enable and a core-sync handshake FSM with timeout.
module safe_cpu_reg_responder #(
    parameter int          NCORES         = 3,
    parameter logic [31:0] BOOT_ADDR_RST  = 32'hF0020000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic [1:0]        mode_o,
    output logic [NCORES-1:0] core_en_o,
    output logic [31:0]       boot_addr_o,
    input  logic [NCORES-1:0] intr_i,
    output logic              irq_o,
    output logic              sync_req_o,
    input  logic [NCORES-1:0] sync_ack_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_TMO} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [1:0]        mode;
    logic [NCORES-1:0] core_en, irq_pend, irq_en;
    logic [31:0]       boot_addr;
    logic              sync_done, sync_tmo, addr_err;
    logic              rvalid_q;
    logic [31:0]       rdata_q, rd_val;

    logic [5:0] idx;
    logic       addr_ok, wr, wr_lo, sync_start, all_ack;
    logic       unused_addr;

    assign unused_addr = ^addr_i[31:8];

    assign idx     = addr_i[7:2];
    assign addr_ok = (addr_i[1:0] == 2'b00) && (idx <= 6'd6);
    assign wr      = req_i && we_i && addr_ok;
    // Everything except BOOT_ADDR is gated on the low byte lane only.
    assign wr_lo   = wr && be_i[0];

    assign sync_start = wr_lo && (idx == 6'd6) && wdata_i[0];
    assign all_ack    = ((sync_ack_i & core_en) == core_en);

    always_comb begin
        rd_val = '0;
        case (idx)
            6'd0: rd_val[1:0]        = mode;
            6'd1: rd_val[NCORES-1:0] = core_en;
            6'd2: rd_val             = boot_addr;
            6'd3: rd_val[3:0]        = {addr_err, sync_tmo, sync_done, state == S_REQ};
            6'd4: rd_val[NCORES-1:0] = irq_pend;
            6'd5: rd_val[NCORES-1:0] = irq_en;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode      <= '0;
            core_en   <= '1;
            boot_addr <= BOOT_ADDR_RST;
            irq_pend  <= '0;
            irq_en    <= '0;
            sync_done <= 1'b0;
            sync_tmo  <= 1'b0;
            addr_err  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (wr_lo && idx == 6'd0 && wdata_i[1:0] != 2'b11) mode <= wdata_i[1:0];
            if (wr_lo && idx == 6'd1) core_en <= wdata_i[NCORES-1:0];
            for (int b = 0; b < 4; b++)
                if (wr && idx == 6'd2 && be_i[b]) boot_addr[8*b +: 8] <= wdata_i[8*b +: 8];
            if (wr_lo && idx == 6'd5) irq_en <= wdata_i[NCORES-1:0];

            // Hardware set beats a same-cycle W1C on every sticky bit.
            irq_pend <= (irq_pend & ~((wr_lo && idx == 6'd4) ? wdata_i[NCORES-1:0] : '0)) | intr_i;

            if (state == S_DONE)                         sync_done <= 1'b1;
            else if (wr_lo && idx == 6'd3 && wdata_i[1]) sync_done <= 1'b0;
            if (state == S_TMO)                          sync_tmo  <= 1'b1;
            else if (wr_lo && idx == 6'd3 && wdata_i[2]) sync_tmo  <= 1'b0;
            if (req_i && !addr_ok)                       addr_err  <= 1'b1;
            else if (wr_lo && idx == 6'd3 && wdata_i[3]) addr_err  <= 1'b0;

            rvalid_q <= req_i;
            rdata_q  <= (req_i && !we_i && addr_ok) ? rd_val : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == S_REQ) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (sync_start) state_nxt = S_REQ;
            S_REQ: begin
                if (all_ack)                                 state_nxt = S_DONE;
                else if (cnt == CW'(TIMEOUT_CYCLES - 1))     state_nxt = S_TMO;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_TMO:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign mode_o      = mode;
    assign core_en_o   = core_en;
    assign boot_addr_o = boot_addr;
    assign irq_o       = |(irq_pend & irq_en);
    assign sync_req_o  = (state == S_REQ);
endmodule

// File: tb/tb_safe_cpu_reg_responder.sv
// Directed bench for safe_cpu_reg_responder; expected read data is queued at
// issue time and a negedge monitor pops it whenever rvalid_o is seen.
module tb_safe_cpu_reg_responder;
    localparam int NC = 3;
    localparam int TO = 32;

    logic          clk = 0;
    logic          rst_i = 1;
    logic          req_i = 0, we_i = 0;
    logic [3:0]    be_i = 4'hF;
    logic [31:0]   addr_i = '0, wdata_i = '0;
    logic          gnt_o, rvalid_o, irq_o, sync_req_o;
    logic [31:0]   rdata_o, boot_addr_o;
    logic [1:0]    mode_o;
    logic [NC-1:0] core_en_o, intr_i = '0, sync_ack_i = '0;

    int total = 0, bad = 0;
    logic [31:0] exp_q[$];

    safe_cpu_reg_responder #(.NCORES(NC), .BOOT_ADDR_RST(32'hF0020000), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .mode_o(mode_o), .core_en_o(core_en_o),
        .boot_addr_o(boot_addr_o), .intr_i(intr_i), .irq_o(irq_o),
        .sync_req_o(sync_req_o), .sync_ack_i(sync_ack_i)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rvalid_o === 1'b1) begin
            logic [31:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rvalid_unexpected: got rdata=%h with nothing outstanding", rdata_o);
            end else begin
                e = exp_q.pop_front();
                if (rdata_o !== e) begin
                    bad++;
                    $display("FAIL rdata: got %h expected %h", rdata_o, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_i = 0; we_i = 0;
        repeat (n) cyc();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        req_i = 1; we_i = 0; be_i = 4'hF; addr_i = a; wdata_i = '0;
        exp_q.push_back(exp);
        cyc();
        req_i = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_i = 1; we_i = 1; be_i = be; addr_i = a; wdata_i = d;
        exp_q.push_back(32'h0);
        cyc();
        req_i = 0; we_i = 0;
    endtask

    // Counts cycles sync_req_o stays high; optional ack after ack_at cycles,
    // optional STATUS read or re-issued SYNC_CMD at poke_at.
    task automatic run_sync(input int ack_at, input logic [NC-1:0] ack_val,
                            input int poke_at, input logic poke_wr, output int cnt);
        cnt = 0;
        while (sync_req_o === 1'b1 && cnt < 4*TO) begin
            cnt++;
            if (cnt == ack_at) sync_ack_i = ack_val;
            if (cnt == poke_at) begin
                req_i = 1; we_i = poke_wr; be_i = 4'hF;
                addr_i = poke_wr ? 32'h18 : 32'h0C; wdata_i = 32'h1;
                exp_q.push_back(poke_wr ? 32'h0 : 32'h1);
            end else begin
                req_i = 0; we_i = 0;
            end
            cyc();
        end
        req_i = 0; we_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) cyc();
        check("rst_rvalid", rvalid_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_mode", mode_o, 0);
        check("rst_core_en", core_en_o, 3'h7);
        check("rst_boot", boot_addr_o, 32'hF0020000);
        check("rst_sync_req", sync_req_o, 0);
        check("rst_irq", irq_o, 0);
        rst_i = 0;
        cyc();

        req_i = 1;
        check("gnt_comb", gnt_o, 1);
        rd(32'h00, 0); rd(32'h04, 32'h7); rd(32'h08, 32'hF0020000);
        rd(32'h0C, 0); rd(32'h10, 0); rd(32'h14, 0); rd(32'h18, 0);
        idle(1);

        wr(32'h08, 32'h12345678, 4'b0011);
        rd(32'h08, 32'hF0025678);
        idle(1);
        check("boot_be", boot_addr_o, 32'hF0025678);

        wr(32'h00, 32'h3, 4'hF); check("mode_w3_from0", mode_o, 0);
        wr(32'h00, 32'h1, 4'hF); check("mode_w1", mode_o, 1);
        wr(32'h00, 32'h3, 4'hF); check("mode_w3_from1", mode_o, 1);
        wr(32'h00, 32'h2, 4'hF); check("mode_w2", mode_o, 2);
        wr(32'h00, 32'h0, 4'b1110); check("mode_be0_low", mode_o, 2);
        rd(32'h00, 32'h2);

        wr(32'h14, 32'h2, 4'hF);
        intr_i = 3'b010; idle(1); intr_i = '0;
        check("irq_set", irq_o, 1);
        intr_i = 3'b010; wr(32'h10, 32'h2, 4'hF); intr_i = '0;
        check("irq_set_wins", irq_o, 1);
        rd(32'h10, 32'h2);
        wr(32'h10, 32'h2, 4'hF);
        check("irq_clr", irq_o, 0);
        intr_i = 3'b001; idle(1); intr_i = '0;
        check("irq_masked", irq_o, 0);
        rd(32'h10, 32'h1);
        wr(32'h10, 32'h1, 4'hF);
        rd(32'h10, 0);

        wr(32'h04, 32'h5, 4'hF);
        wr(32'h18, 32'h1, 4'hF);
        run_sync(10, 3'b101, 3, 1'b0, n);
        check("sync_ack_len", n, 10);
        idle(1);
        rd(32'h0C, 32'h2);
        sync_ack_i = '0;
        wr(32'h0C, 32'h2, 4'hF);
        rd(32'h0C, 0);

        wr(32'h18, 32'h1, 4'hF);
        run_sync(0, '0, 5, 1'b1, n);
        check("sync_tmo_len", n, TO);
        idle(1);
        rd(32'h0C, 32'h4);
        wr(32'h0C, 32'h4, 4'hF);

        wr(32'h04, 32'h0, 4'hF);
        wr(32'h18, 32'h1, 4'hF);
        run_sync(0, '0, 0, 1'b0, n);
        check("sync_noen_len", n, 1);
        idle(1);
        rd(32'h0C, 32'h2);
        wr(32'h0C, 32'h2, 4'hF);

        rd(32'h40, 0);
        rd(32'h02, 0);
        wr(32'h01, 32'h1, 4'hF);
        rd(32'h0C, 32'h8);
        check("misaligned_wr_dropped", mode_o, 2);

        wr(32'h04, 32'h3, 4'hF);
        wr(32'h18, 32'h1, 4'hF);
        idle(3);
        check("sync_running", sync_req_o, 1);
        rst_i = 1; req_i = 1; we_i = 0; addr_i = 32'h00;
        cyc();
        req_i = 0; rst_i = 0;
        check("rst2_sync_req", sync_req_o, 0);
        check("rst2_rvalid", rvalid_o, 0);
        check("rst2_rdata", rdata_o, 0);
        check("rst2_mode", mode_o, 0);
        check("rst2_core_en", core_en_o, 3'h7);
        check("rst2_boot", boot_addr_o, 32'hF0020000);
        rd(32'h0C, 0);
        rd(32'h14, 0);
        idle(3);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/safe_cpu_reg_responder.md
Name: safe_cpu_reg_responder

Overview:
OBI responder for the SAFE_CPU_REGISTER slave window of the system crossbar (base 0xF0012000, size 0x100, slave index 5). It holds the safe-CPU configuration registers: redundancy mode, core enables, boot address and interrupt pend/enable. It also runs a core-synchronisation handshake FSM with timeout. Cores and the external master reach it through the system crossbar; its outputs drive the CPU cluster control logic.

Parameters:
NCORES, 3, number of cores (width of core_en/sync/intr vectors)
BOOT_ADDR_RST, 32'hF0020000, reset value of BOOT_ADDR (RAM0 start)
TIMEOUT_CYCLES, 1024, max cycles in SYNC_REQ before timeout (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_i  in  1  OBI request
we_i  in  1  OBI write enable
be_i  in  4  OBI byte enables
addr_i  in  32  OBI address; only [7:2] decoded
wdata_i  in  32  OBI write data
gnt_o  out  1  OBI grant
rvalid_o  out  1  OBI response valid
rdata_o  out  32  OBI read data
mode_o  out  2  redundancy mode
core_en_o  out  NCORES  core enable mask
boot_addr_o  out  32  boot address
intr_i  in  NCORES  per-core event pulses, set IRQ_PEND
irq_o  out  1  interrupt
sync_req_o  out  1  sync request to cores
sync_ack_i  in  NCORES  per-core sync acknowledge (level)

Behaviour:
- Interface decided: one clock clk_i; reset rst_i synchronous, active-high.
- Handshake: gnt_o = req_i (combinational, always grant). An accepted request (req_i & gnt_o at a rising edge) gives rvalid_o=1 on the next cycle only. rdata_o is registered and valid with rvalid_o. Back-to-back requests give back-to-back rvalid. For writes, rdata_o=0.
- Register writes take effect at the grant edge and are visible to a read granted the next cycle.
- Register map (offset = addr_i[7:0]):
  - 0x00 MODE[1:0], RW, reset 0. Values: 0 single, 1 DMR, 2 TMR. A write of 3 is ignored and the old value is kept.
  - 0x04 CORE_EN[NCORES-1:0], RW, reset all ones.
  - 0x08 BOOT_ADDR, RW, reset BOOT_ADDR_RST. Per-byte writes honour be_i.
  - 0x0C STATUS, RO except the W1C bits: bit0 sync_busy (RO), bit1 sync_done (W1C), bit2 sync_timeout (W1C), bit3 addr_err (W1C).
  - 0x10 IRQ_PEND[NCORES-1:0], W1C. Set by intr_i. A hardware set and a W1C on the same bit in the same cycle: set wins.
  - 0x14 IRQ_EN[NCORES-1:0], RW, reset 0.
  - 0x18 SYNC_CMD, WO, reads 0. Writing bit0=1 starts sync when the FSM is IDLE; ignored otherwise.
- Byte enables on non-BOOT_ADDR registers: the write applies only if be_i[0]=1.
- Unused bits read 0.
- Any access to an unmapped offset, or not word-aligned (addr_i[1:0]!=0): write dropped, read returns 0, addr_err set. Response timing is unchanged.
- irq_o = |(IRQ_PEND & IRQ_EN), combinational from registers.
- Sync FSM:
  - IDLE -> REQ on a SYNC_CMD write. The timeout counter clears on entry.
  - REQ: sync_req_o=1, sync_busy=1, counter increments each cycle.
    - If (sync_ack_i & CORE_EN) == CORE_EN -> DONE. With CORE_EN=0 this holds on the first REQ cycle.
    - Else if counter == TIMEOUT_CYCLES-1 -> TIMEOUT.
    - If ack and the timeout limit coincide, ack wins.
  - DONE: one cycle, sync_done set, sync_req_o=0 -> IDLE.
  - TIMEOUT: one cycle, sync_timeout set, sync_req_o=0 -> IDLE.
  - CORE_EN is sampled live during REQ.
- Reset, including mid-transaction or mid-sync: FSM goes to IDLE, all registers take their reset values, rvalid_o=0, rdata_o=0, sync_req_o=0. A request pending at the reset edge gets no response.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08 back-to-back -> rvalid on 3 consecutive cycles, rdata 0, 0x7, 0xF0020000. Outputs match mode_o=0, core_en_o=7, boot_addr_o=0xF0020000.
- Write BOOT_ADDR 0x12345678 with be=4'b0011, then read -> 0xF0025678. Write MODE=3 -> mode_o stays at its prior value; write MODE=2 -> mode_o=2 next cycle.
- intr_i[1] pulse with IRQ_EN=0x2 -> irq_o=1. A W1C of 0x2 in the same cycle as another intr_i[1] pulse -> pend stays 1. A later W1C of 0x2 -> irq_o=0.
- CORE_EN=0x5, write SYNC_CMD=1, drive sync_ack_i=0x5 after 10 cycles -> sync_req_o high ~10 cycles, STATUS reads 0x2. W1C 0x2 -> STATUS reads 0.
- SYNC with sync_ack_i=0 -> sync_req_o high exactly TIMEOUT_CYCLES cycles, then STATUS bit2=1. A second SYNC_CMD write during REQ is ignored.
- Read 0x40 and 0x02 -> rdata 0, rvalid still on the next cycle, STATUS bit3=1. Assert rst_i mid-sync -> sync_req_o=0 and all registers at reset values on the cycle after.
